bundle_dispatcher: RTL and testbench

//  Issue side of the functional-unit instruction interface. Accepts one VLIW bundle from fetch

---
 rtl/vliw_pkg.sv | 14 +
 rtl/dispatch_slot_tracker.sv | 24 ++
 rtl/bundle_dispatcher.sv | 108 ++++++++++
 tb/tb_bundle_dispatcher.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared widths, dispatcher state encoding and the canonical NOP word for the VLIW issue path.
package vliw_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/dispatch_slot_tracker.sv
// Per-slot completion tracker: remembers that the FU has started, reports done once it has
// gone idle again (or immediately when the slot carries no instruction).
module dispatch_slot_tracker (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic mask,
  input  logic fu_working,
  output logic done
);

  logic started;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      started <= 1'b0;
    end else if (fu_working) begin
      started <= 1'b1;
    end
  end

  assign done = !mask || (started && !fu_working);

endmodule

// File: rtl/bundle_dispatcher.sv
// Issue side of the FU interface: accepts one bundle, pulses per-slot instructionReady for one
// cycle, then blocks fetch until every issued FU has worked and gone idle, or the wait times out.
module bundle_dispatcher
  import vliw_pkg::*;
#(
  parameter int NUM_FU  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bundle_valid,
  output logic                      bundle_ready,
  input  logic [NUM_FU*INSTR_W-1:0] bundle_data,
  input  logic [NUM_FU-1:0]         bundle_slot_valid,
  input  logic [ADDR_W-1:0]         bundle_addr,
  output logic [NUM_FU*INSTR_W-1:0] fu_instruction,
  output logic [ADDR_W-1:0]         fu_bundle_addr,
  output logic [NUM_FU-1:0]         fu_instruction_ready,
  input  logic [NUM_FU-1:0]         fu_working,
  output logic                      busy,
  output logic                      fault,
  output logic [31:0]               bundles_retired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  dispatch_state_t   state, state_next;
  logic [NUM_FU-1:0] mask;
  logic [NUM_FU-1:0] done;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept, all_done, at_limit;
  logic              retire, time_out;

  assign bundle_ready = (state == IDLE) && !rst && (fu_working == '0);
  assign accept       = bundle_valid && bundle_ready;
  assign all_done     = &done;
  assign at_limit     = (wait_cnt == CNT_W'(TIMEOUT - 1));

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    dispatch_slot_tracker u_tracker (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept),
      .mask       (mask[i]),
      .fu_working (fu_working[i]),
      .done       (done[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (all_done || at_limit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Completion on the limit cycle counts as a retire, not a timeout.
  always_comb begin
    retire   = 1'b0;
    time_out = 1'b0;
    if (state == WAIT) begin
      retire   = all_done;
      time_out = !all_done && at_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fu_instruction       <= '0;
      fu_bundle_addr       <= '0;
      fu_instruction_ready <= '0;
      mask                 <= '0;
      wait_cnt             <= '0;
      busy                 <= 1'b0;
      fault                <= 1'b0;
      bundles_retired      <= '0;
    end else begin
      fu_instruction_ready <= '0;
      busy                 <= (state_next != IDLE);
      if (accept) begin
        fu_instruction       <= bundle_data;
        fu_bundle_addr       <= bundle_addr;
        fu_instruction_ready <= bundle_slot_valid;
        mask                 <= bundle_slot_valid;
        wait_cnt             <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (retire) begin
        bundles_retired <= bundles_retired + 32'd1;
      end
      if (time_out) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bundle_dispatcher.sv
// Directed plus randomized bench for bundle_dispatcher with simple FU latency models.
module tb_bundle_dispatcher;
  import vliw_pkg::*;

  localparam int NUM_FU  = 4;
  localparam int TIMEOUT = 64;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      bundle_valid;
  logic                      bundle_ready;
  logic [NUM_FU*INSTR_W-1:0] bundle_data;
  logic [NUM_FU-1:0]         bundle_slot_valid;
  logic [ADDR_W-1:0]         bundle_addr;
  logic [NUM_FU*INSTR_W-1:0] fu_instruction;
  logic [ADDR_W-1:0]         fu_bundle_addr;
  logic [NUM_FU-1:0]         fu_instruction_ready;
  logic [NUM_FU-1:0]         fu_working;
  logic                      busy;
  logic                      fault;
  logic [31:0]               bundles_retired;

  int checks = 0;
  int errors = 0;

  // Reference state: what the bench expects from the rules alone.
  logic [31:0] exp_retired;
  logic        exp_fault;

  // FU models: after a ready pulse, working is high for lat[i] cycles.
  int lat[NUM_FU];
  int rem[NUM_FU];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (rst) rem[i] <= 0;
      else if (fu_instruction_ready[i]) rem[i] <= lat[i];
      else if (rem[i] > 0) rem[i] <= rem[i] - 1;
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign fu_working[g] = (rem[g] != 0);
  end

  bundle_dispatcher #(.NUM_FU(NUM_FU), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bundle_valid         (bundle_valid),
    .bundle_ready         (bundle_ready),
    .bundle_data          (bundle_data),
    .bundle_slot_valid    (bundle_slot_valid),
    .bundle_addr          (bundle_addr),
    .fu_instruction       (fu_instruction),
    .fu_bundle_addr       (fu_bundle_addr),
    .fu_instruction_ready (fu_instruction_ready),
    .fu_working           (fu_working),
    .busy                 (busy),
    .fault                (fault),
    .bundles_retired      (bundles_retired)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  // Called at a negedge. Presents the bundle, waits for the handshake, then follows WAIT
  // to the end and compares against the expected length, pulse and counters.
  task automatic run_bundle(input logic [127:0] data, input logic [3:0] slots,
                            input logic [63:0] addr, input bit keep_valid);
    int n, worst, exp_n;
    bit timed_out, late_pulse;
    bundle_data       = data;
    bundle_slot_valid = slots;
    bundle_addr       = addr;
    bundle_valid      = 1'b1;
    n = 0;
    while (!bundle_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait_bound", n < 300, 1'b1);
    @(posedge clk);
    #1;
    if (!keep_valid) bundle_valid = 1'b0;

    worst = 0;
    for (int i = 0; i < NUM_FU; i++)
      if (slots[i] && lat[i] + 2 > worst) worst = lat[i] + 2;
    timed_out = (worst > TIMEOUT);
    exp_n     = (slots == 4'b0000) ? 1 : (timed_out ? TIMEOUT : worst);

    n = 0;
    late_pulse = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 1) begin
        chk("pulse", fu_instruction_ready, slots);
        chk("instr", fu_instruction, data);
        chk("addr", fu_bundle_addr, addr);
        chk("idle_at_pulse", fu_working, 4'b0000);
      end else if (fu_instruction_ready != 0) begin
        late_pulse = 1'b1;
      end
    end
    if (timed_out) exp_fault = 1'b1;
    else exp_retired = exp_retired + 32'd1;
    chk("wait_cycles", n, exp_n);
    chk("single_pulse", late_pulse, 1'b0);
    chk("retired", bundles_retired, exp_retired);
    chk("fault", fault, exp_fault);
    chk("ready_after", bundle_ready, !timed_out);
  endtask

  task automatic drain_fus();
    int n = 0;
    while (fu_working != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", n < 300, 1'b1);
  endtask

  initial begin
    logic [127:0] d;
    bundle_valid      = 1'b0;
    bundle_data       = '0;
    bundle_slot_valid = '0;
    bundle_addr       = '0;
    exp_retired       = '0;
    exp_fault         = 1'b0;
    set_lat(3, 3, 3, 3);

    repeat (3) @(negedge clk);
    chk("rst_ready", bundle_ready, 1'b0);
    chk("rst_instr", fu_instruction, 128'd0);
    chk("rst_addr", fu_bundle_addr, 64'd0);
    chk("rst_pulse", fu_instruction_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_retired", bundles_retired, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bundle_ready, 1'b1);

    // Full bundle, 3-cycle FUs: five WAIT cycles.
    d = {NOP, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001};
    run_bundle(d, 4'b1111, 64'h1000, 1'b0);

    // Partial mask, then empty bundle.
    set_lat(2, 0, 2, 0);
    d = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    run_bundle(d, 4'b0101, 64'h2000, 1'b0);
    run_bundle(d, 4'b0000, 64'h2010, 1'b0);

    // Completion on the last permitted cycle retires without fault.
    set_lat(62, 1, 1, 1);
    run_bundle({4{NOP}}, 4'b0001, 64'h3000, 1'b0);

    // FU2 stuck long enough to hit the timeout; fault stays set afterwards.
    set_lat(2, 2, 200, 2);
    run_bundle({4{32'hDEAD_BEEF}}, 4'b0100, 64'h4000, 1'b0);
    drain_fus();
    set_lat(2, 2, 2, 2);
    run_bundle({4{32'h1234_5678}}, 4'b1111, 64'h4100, 1'b0);

    // Valid held high across three bundles with a slow FU2.
    set_lat(3, 3, 5, 3);
    for (int b = 0; b < 3; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_bundle(d, 4'b1111, 64'h5000 + 64'(b * 16), 1'b1);
    end
    bundle_valid = 1'b0;

    for (int b = 0; b < 10; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NUM_FU; i++) lat[i] = $urandom_range(1, 6);
      run_bundle(d, 4'($urandom), {$urandom, $urandom}, 1'($urandom));
    end
    bundle_valid = 1'b0;
    @(negedge clk);

    // Reset two cycles into WAIT abandons the bundle.
    set_lat(3, 3, 3, 3);
    bundle_data       = {4{32'h5555_AAAA}};
    bundle_slot_valid = 4'b1111;
    bundle_addr       = 64'h6000;
    bundle_valid      = 1'b1;
    @(posedge clk);
    #1;
    bundle_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", bundle_ready, 1'b0);
    chk("mid_rst_instr", fu_instruction, 128'd0);
    chk("mid_rst_addr", fu_bundle_addr, 64'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fault", fault, 1'b0);
    chk("mid_rst_retired", bundles_retired, 32'd0);
    exp_retired = '0;
    exp_fault   = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_rst", bundle_ready, 1'b1);
    run_bundle({4{32'h0BAD_F00D}}, 4'b1011, 64'h6100, 1'b0);

    // Retired counter wraps from all-ones to zero.
    force dut.bundles_retired = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.bundles_retired;
    @(negedge clk);
    exp_retired = 32'hFFFF_FFFF;
    chk("preload", bundles_retired, exp_retired);
    run_bundle({4{NOP}}, 4'b1111, 64'h7000, 1'b0);
    chk("wrapped", bundles_retired, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
